// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline control slice: instruction codes,
// status codes, the "no register" id and the run/halt controller states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ctl_state_e;

  function automatic logic is_exc(input logic [1:0] stat);
    return stat != S_AOK;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign q = count_q;

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline hazard/control unit with a run/halt controller that freezes
// the pipe on the first retired exception, saturating perf counters and a watchdog.
module pipe_control
  import y86_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int WDOG  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             set_cc,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [1:0]       exc_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic             wdog_timeout
);

  ctl_state_e state_q;
  logic [1:0] exc_stat_q;
  logic       wdog_q;
  logic       run;
  logic       lu;
  logic       mp;
  logic       rt;
  logic       retire_ev;

  assign run = (state_q == ST_RUN);

  always_comb begin
    lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp = (E_icode == I_JXX) && !e_Cnd;
    rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  end

  // Reset flushes everything; HALTED holds every register and bubbles everything behind it.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    set_cc   = 1'b0;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    if (!rst) begin
      if (state_q == ST_HALTED) begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        W_stall = 1'b1;
      end else begin
        F_stall  = lu | rt;
        D_stall  = lu;
        D_bubble = mp | (!lu & rt);
        E_bubble = mp | lu;
        set_cc   = (E_icode == I_OPQ) && !is_exc(m_stat) && !is_exc(W_stat);
        M_bubble = is_exc(m_stat) | is_exc(W_stat);
        W_stall  = is_exc(W_stat);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      exc_stat_q <= S_AOK;
    end else if ((state_q == ST_RUN) && is_exc(W_stat)) begin
      state_q    <= ST_HALTED;
      exc_stat_q <= W_stat;
    end
  end

  assign halted   = (state_q == ST_HALTED);
  assign exc_stat = exc_stat_q;

  assign retire_ev = run && (W_icode != I_NOP) && !W_stall;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(rst), .en(run), .q(cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk(clk), .rst(rst), .en(retire_ev), .q(retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst(rst), .en(run && lu), .q(lu_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk(clk), .rst(rst), .en(run && mp), .q(mispred_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk(clk), .rst(rst), .en(run && rt && !lu), .q(ret_cnt)
  );

  // The idle counter is wide enough to reach WDOG, so it can never wrap back onto the limit.
  generate
    if (WDOG > 0) begin : g_wdog
      localparam int IDLE_W = (WDOG > 1) ? $clog2(WDOG + 1) : 1;
      localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(WDOG - 1);
      logic [IDLE_W-1:0] idle_q;

      sat_counter #(.W(IDLE_W)) u_idle (
        .clk(clk), .rst(rst || retire_ev), .en(run), .q(idle_q)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          wdog_q <= 1'b0;
        end else if (idle_q == IDLE_LIMIT) begin
          wdog_q <= 1'b1;
        end
      end
    end else begin : g_no_wdog
      always_ff @(posedge clk) begin
        wdog_q <= 1'b0;
      end
    end
  endgenerate

  assign wdog_timeout = wdog_q;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: a 32-bit/WDOG=24 instance and a 4-bit/WDOG=8 instance share
// one input stream and are checked every cycle against a behavioural model.
module tb_pipe_control;

  localparam int WDOG_A = 24;
  localparam int WDOG_B = 8;

  localparam logic [3:0] NOP = 4'h1, MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7, RET = 4'h9, POPQ = 4'hB;
  localparam logic [3:0] RNONE = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic       e_Cnd;
  logic [1:0] m_stat, W_stat;

  logic a_F_stall, a_D_stall, a_D_bubble, a_E_bubble, a_set_cc, a_M_bubble, a_W_stall;
  logic a_halted, a_wdog;
  logic [1:0] a_exc_stat;
  logic [31:0] a_cycle_cnt, a_retire_cnt, a_lu_cnt, a_mispred_cnt, a_ret_cnt;

  logic b_F_stall, b_D_stall, b_D_bubble, b_E_bubble, b_set_cc, b_M_bubble, b_W_stall;
  logic b_halted, b_wdog;
  logic [1:0] b_exc_stat;
  logic [3:0] b_cycle_cnt, b_retire_cnt, b_lu_cnt, b_mispred_cnt, b_ret_cnt;

  pipe_control #(.CNT_W(32), .WDOG(WDOG_A)) dut_a (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
    .F_stall(a_F_stall), .D_stall(a_D_stall), .D_bubble(a_D_bubble), .E_bubble(a_E_bubble),
    .set_cc(a_set_cc), .M_bubble(a_M_bubble), .W_stall(a_W_stall), .halted(a_halted),
    .exc_stat(a_exc_stat), .cycle_cnt(a_cycle_cnt), .retire_cnt(a_retire_cnt),
    .lu_cnt(a_lu_cnt), .mispred_cnt(a_mispred_cnt), .ret_cnt(a_ret_cnt), .wdog_timeout(a_wdog)
  );

  pipe_control #(.CNT_W(4), .WDOG(WDOG_B)) dut_b (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
    .F_stall(b_F_stall), .D_stall(b_D_stall), .D_bubble(b_D_bubble), .E_bubble(b_E_bubble),
    .set_cc(b_set_cc), .M_bubble(b_M_bubble), .W_stall(b_W_stall), .halted(b_halted),
    .exc_stat(b_exc_stat), .cycle_cnt(b_cycle_cnt), .retire_cnt(b_retire_cnt),
    .lu_cnt(b_lu_cnt), .mispred_cnt(b_mispred_cnt), .ret_cnt(b_ret_cnt), .wdog_timeout(b_wdog)
  );

  logic [6:0] a_ctl, b_ctl;
  assign a_ctl = {a_F_stall, a_D_stall, a_D_bubble, a_E_bubble, a_set_cc, a_M_bubble, a_W_stall};
  assign b_ctl = {b_F_stall, b_D_stall, b_D_bubble, b_E_bubble, b_set_cc, b_M_bubble, b_W_stall};

  // Reference model state
  bit         m_halt, wd_a, wd_b;
  logic [1:0] m_exc;
  longint     m_cyc, m_ret, m_lu, m_mp, m_rt, idle_a, idle_b;
  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic void hazards(output bit lu, output bit mp, output bit rt);
    lu = ((E_icode == MRMOVQ) || (E_icode == POPQ)) && (E_dstM != RNONE) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp = (E_icode == JXX) && !e_Cnd;
    rt = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
  endfunction

  // {F_stall, D_stall, D_bubble, E_bubble, set_cc, M_bubble, W_stall}
  function automatic logic [6:0] model_ctl();
    bit lu, mp, rt;
    if (rst) return 7'b0011010;
    if (m_halt) return 7'b1111011;
    hazards(lu, mp, rt);
    return {lu | rt, lu, mp | (!lu && rt), mp | lu,
            (E_icode == OPQ) && (m_stat == 2'd0) && (W_stat == 2'd0),
            (m_stat != 2'd0) || (W_stat != 2'd0), W_stat != 2'd0};
  endfunction

  task automatic model_edge();
    bit lu, mp, rt;
    if (rst) begin
      m_halt = 0; m_exc = 2'd0; wd_a = 0; wd_b = 0;
      m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0; m_rt = 0; idle_a = 0; idle_b = 0;
    end else begin
      if (idle_a == WDOG_A - 1) wd_a = 1;
      if (idle_b == WDOG_B - 1) wd_b = 1;
      if (!m_halt) begin
        hazards(lu, mp, rt);
        m_cyc++;
        if ((W_icode != NOP) && (W_stat == 2'd0)) begin
          m_ret++; idle_a = 0; idle_b = 0;
        end else begin
          idle_a++; idle_b++;
        end
        if (lu) m_lu++;
        if (mp) m_mp++;
        if (rt && !lu) m_rt++;
        if (W_stat != 2'd0) begin
          m_halt = 1;
          m_exc  = W_stat;
        end
      end
    end
  endtask

  task automatic compare();
    logic [6:0] e;
    e = exp_q.pop_front();
    check("ctl_a", a_ctl, e);
    check("ctl_b", b_ctl, e);
    check("halted_a", a_halted, m_halt);
    check("halted_b", b_halted, m_halt);
    check("exc_stat_a", a_exc_stat, m_exc);
    check("exc_stat_b", b_exc_stat, m_exc);
    check("cycle_cnt_a", a_cycle_cnt, m_cyc);
    check("retire_cnt_a", a_retire_cnt, m_ret);
    check("lu_cnt_a", a_lu_cnt, m_lu);
    check("mispred_cnt_a", a_mispred_cnt, m_mp);
    check("ret_cnt_a", a_ret_cnt, m_rt);
    check("cycle_cnt_b", b_cycle_cnt, sat4(m_cyc));
    check("retire_cnt_b", b_retire_cnt, sat4(m_ret));
    check("lu_cnt_b", b_lu_cnt, sat4(m_lu));
    check("mispred_cnt_b", b_mispred_cnt, sat4(m_mp));
    check("ret_cnt_b", b_ret_cnt, sat4(m_rt));
    check("wdog_a", a_wdog, wd_a);
    check("wdog_b", b_wdog, wd_b);
  endtask

  // One clock: check current outputs against the model, then advance the model at the edge.
  task automatic cycle();
    exp_q.push_back(model_ctl());
    #1;
    compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; D_icode = NOP; E_icode = NOP; M_icode = NOP; W_icode = NOP;
    d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE; e_Cnd = 1'b1;
    m_stat = 2'd0; W_stat = 2'd0;
  endtask

  task automatic expect_ctl(input string tag, input logic [6:0] e);
    #1;
    check(tag, a_ctl, e);
  endtask

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 4) == 4) ? RNONE : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cycle();
    rst = 1'b0;
    check("rst_halted", a_halted, 0);
    check("rst_cycle_cnt", a_cycle_cnt, 0);

    // Watchdog at 8 idle cycles and 4-bit saturation after 20 run cycles
    for (int i = 0; i < 7; i++) cycle();
    check("wdog_before_8", b_wdog, 0);
    cycle();
    check("wdog_at_8", b_wdog, 1);
    for (int i = 0; i < 12; i++) cycle();
    check("sat_cycle_cnt", b_cycle_cnt, 15);
    check("full_cycle_cnt", a_cycle_cnt, 20);

    rst = 1'b1; cycle(); idle_inputs();

    E_icode = MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
    expect_ctl("load_use_ctl", 7'b1101000);
    cycle(); idle_inputs(); cycle();
    check("load_use_cnt", a_lu_cnt, 1);

    E_icode = JXX; e_Cnd = 1'b0;
    expect_ctl("mispred_ctl", 7'b0011000);
    cycle(); idle_inputs(); cycle();
    check("mispred_cnt", a_mispred_cnt, 1);

    for (int i = 0; i < 3; i++) begin
      D_icode = RET;
      expect_ctl("ret_ctl", 7'b1010000);
      cycle();
    end
    idle_inputs(); cycle();
    check("ret_cnt3", a_ret_cnt, 3);

    M_icode = RET; E_icode = MRMOVQ; E_dstM = 4'd3; d_srcB = 4'd3;
    expect_ctl("ret_lu_ctl", 7'b1101000);
    cycle(); idle_inputs(); cycle();
    check("ret_lu_ret_cnt", a_ret_cnt, 3);
    check("ret_lu_lu_cnt", a_lu_cnt, 2);

    E_icode = OPQ;
    expect_ctl("opq_set_cc", 7'b0000100);
    cycle();
    m_stat = 2'd2;
    expect_ctl("m_exc_ctl", 7'b0000010);
    cycle(); idle_inputs();
    W_stat = 2'd2; W_icode = OPQ;
    expect_ctl("w_exc_ctl", 7'b0000011);
    cycle(); idle_inputs();
    check("halt_halted", a_halted, 1);
    check("halt_exc_stat", a_exc_stat, 2);
    expect_ctl("halted_ctl", 7'b1111011);
    for (int i = 0; i < 3; i++) begin
      E_icode = MRMOVQ; E_dstM = 4'd1; d_srcA = 4'd1; W_icode = OPQ;
      cycle();
    end
    idle_inputs();

    rst = 1'b1;
    expect_ctl("rst_ctl", 7'b0011010);
    cycle(); idle_inputs();
    check("rst_mid_halted", a_halted, 0);
    check("rst_mid_cycle_cnt", a_cycle_cnt, 0);
    check("rst_mid_lu_cnt", a_lu_cnt, 0);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      W_icode = 4'($urandom_range(0, 11));
      d_srcA  = rand_reg();
      d_srcB  = rand_reg();
      E_dstM  = rand_reg();
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_stat  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
